// File: rtl/reg_file_32x32_pkg.sv
// Shared constants and helpers for the 32x32 architectural register file.
package reg_file_32x32_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return (addr == ZERO_REG);
  endfunction

endpackage

// File: rtl/mux_32_32.sv
// 32:1 read-select mux; one instance per register-file read port.
module mux_32_32 #(
  parameter int W = 32
) (
  input  logic [31:0][W-1:0] din,
  input  logic [4:0]         sel,
  output logic [W-1:0]       dout
);

  // Plain indexed select of the registered word.
  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/reg_file_32x32_decoder.sv
// Write-enable decoder: one-hot per-register enables, bit 0 permanently low
// so the zero register can never be selected for a write.
module decoder_5_32
  import reg_file_32x32_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [REG_COUNT-1:0]  onehot
);

  // One-hot decode gated by en; an unknown en or addr leaves bit 0 at zero.
  always_comb begin
    onehot = 32'd0;
    if (en == 1'b1) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (addr == 5'(i)) begin
          onehot[i] = 1'b1;
        end else begin
          onehot[i] = 1'b0;
        end
      end
    end else begin
      onehot = 32'd0;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// Architectural register file: 31 async-cleared registers plus a hardwired
// zero register, one synchronous write port and two combinational read ports.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0]             wen_s;
  logic [NREG-1:0][DATA_W-1:0] reg_bus_s;
  logic [DATA_W-1:0]           mux1_s;
  logic [DATA_W-1:0]           mux2_s;

  decoder_5_32 u_dec (
    .en     (we),
    .addr   (waddr),
    .onehot (wen_s)
  );

  assign reg_bus_s[0] = {DATA_W{1'b0}};

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [DATA_W-1:0] reg_d;
    logic [DATA_W-1:0] reg_q;

    // Load on this register's enable, otherwise hold.
    always_comb begin
      if (wen_s[i]) begin
        reg_d = wdata;
      end else begin
        reg_d = reg_q;
      end
    end

    // Storage flop with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= {DATA_W{1'b0}};
      end else begin
        reg_q <= reg_d;
      end
    end

    assign reg_bus_s[i] = reg_q;
  end

  mux_32_32 #(.W(DATA_W)) u_mux1 (
    .din  (reg_bus_s),
    .sel  (raddr1),
    .dout (mux1_s)
  );

  mux_32_32 #(.W(DATA_W)) u_mux2 (
    .din  (reg_bus_s),
    .sel  (raddr2),
    .dout (mux2_s)
  );

  // Output stage: forced zero in reset, optional same-cycle write forwarding
  // that never applies to the zero register.
  always_comb begin
    rdata1 = {DATA_W{1'b0}};
    rdata2 = {DATA_W{1'b0}};
    if (!rst_n) begin
      rdata1 = {DATA_W{1'b0}};
      rdata2 = {DATA_W{1'b0}};
    end else begin
      if (BYPASS && (we == 1'b1) && (waddr == raddr1) && !is_zero_reg(raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = mux1_s;
      end
      if (BYPASS && (we == 1'b1) && (waddr == raddr2) && !is_zero_reg(raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = mux2_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed scoreboard bench: runs a BYPASS=0 and a BYPASS=1 instance side by side.
module tb_reg_file_32x32;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        we     = 1'b0;
  logic [4:0]  waddr  = 5'd0;
  logic [4:0]  raddr1 = 5'd0;
  logic [4:0]  raddr2 = 5'd0;
  logic [31:0] wdata  = 32'd0;
  logic [31:0] r1_0, r2_0, r1_1, r2_1;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  reg_file_32x32 #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_0), .rdata2(r2_0)
  );

  reg_file_32x32 #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_1), .rdata2(r2_1)
  );

  // Expected read value from the bench's own register image.
  function automatic logic [31:0] rd_exp(input bit byp, input logic [4:0] ra);
    if (!rst_n) return 32'd0;
    if (ra == 5'd0) return 32'd0;
    if (byp && we && (waddr == ra)) return wdata;
    return model[ra];
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic check4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    #1;
    cmp({tag, "/b0_r1"}, r1_0);
    cmp({tag, "/b0_r2"}, r2_0);
    cmp({tag, "/b1_r1"}, r1_1);
    cmp({tag, "/b1_r2"}, r2_1);
  endtask

  task automatic check_model(input string tag);
    check4(tag, rd_exp(1'b0, raddr1), rd_exp(1'b0, raddr2),
                rd_exp(1'b1, raddr1), rd_exp(1'b1, raddr2));
  endtask

  task automatic tick();
    if (rst_n && we && (waddr != 5'd0)) model[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    clear_model();

    check4("reset_initial", 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every register with ones, then reset mid-cycle.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'hFFFF_FFFF;
      tick();
    end
    we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd30;
    check4("fill_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      check4("reset_async", 32'd0, 32'd0, 32'd0, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Write pattern i*0x01010101, reading the mirror address on port 2.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h0101_0101;
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      tick();
      check_model("write_read");
    end
    raddr1 = 5'd5; raddr2 = 5'd26;
    check4("pattern_lit", 32'h0505_0505, 32'h1A1A_1A1A, 32'h0505_0505, 32'h1A1A_1A1A);

    // Writes to register 0 are dropped.
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr1 = 5'd0; raddr2 = 5'd0;
    check4("zero_before", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check4("zero_after", 32'd0, 32'd0, 32'd0, 32'd0);
    we = 1'b0;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      check_model("zero_no_side_effect");
    end

    // Enable gating.
    we = 1'b0; waddr = 5'd5; wdata = 32'h1234_5678; raddr1 = 5'd5; raddr2 = 5'd5;
    tick();
    check4("we_gate", 32'h0505_0505, 32'h0505_0505, 32'h0505_0505, 32'h0505_0505);

    // Read during write on register 7.
    we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_0000;
    tick();
    wdata = 32'h0000_BBBB; raddr1 = 5'd7; raddr2 = 5'd7;
    check4("rdw_before", 32'hAAAA_0000, 32'hAAAA_0000, 32'h0000_BBBB, 32'h0000_BBBB);
    tick();
    check4("rdw_after", 32'h0000_BBBB, 32'h0000_BBBB, 32'h0000_BBBB, 32'h0000_BBBB);
    we = 1'b0;

    // Reset asserted on the same edge as a write to register 3.
    we = 1'b1; waddr = 5'd3; wdata = 32'h5555_5555; raddr1 = 5'd3; raddr2 = 5'd7;
    @(posedge clk);
    rst_n = 1'b0;
    clear_model();
    check4("reset_at_edge", 32'd0, 32'd0, 32'd0, 32'd0);
    wdata = 32'h0000_0003;
    #2;
    rst_n = 1'b1;
    check_model("post_reset_pre_edge");
    tick();
    check4("post_reset_write", 32'h0000_0003, 32'd0, 32'h0000_0003, 32'd0);
    we = 1'b0;
    check_model("post_reset_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- Processor architectural register file: 32 registers x 32 bits, two combinational read ports, one synchronous write port.
- Sits directly upstream of the 32:1 x 32-bit read-select mux (mux_32_32). Each read port drives one mux_32_32 instance with the 32 register outputs, using the read address as the mux select.
- The writeback stage drives the write port. Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W = 32.
- BYPASS, 0, when 1, a read of the register being written in the same cycle returns the write data; when 0, it returns the stored (old) value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_W  write register address.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low immediately clears registers 1..31 to 0, independent of clk.
  - rdata1 and rdata2 read 0 for every address while rst_n is low.
- Write:
  - On each rising clk with rst_n high, we=1 and waddr!=0: the addressed register takes wdata.
  - All other registers hold their value.
  - Write latency is 1 cycle: the new value is visible on the read ports after that edge.
- Register 0:
  - Never written; writes to address 0 are silently dropped.
  - Reads of address 0 always return 0.
- Write-enable decode: a one-hot 32-bit enable vector, decoded from waddr and gated by we. Bit 0 is forced to 0. At most one register is written per cycle.
- Read:
  - Purely combinational: rdata = reg[raddr], with zero clock latency.
  - Both ports are independent and may use the same address at the same time; both then return identical data.
- Read-during-write, same address (nonzero, we=1):
  - BYPASS=0: rdata returns the old value before the edge and the new value after it.
  - BYPASS=1: rdata returns wdata combinationally in that cycle.
  - Address 0 is never bypassed, for either setting.
- Reset during operation:
  - Asserting rst_n coincident with a clk edge discards that cycle's write.
  - After rst_n deasserts, the first write takes effect on the first rising clk at which rst_n is high.
- Unknown inputs: an X on we or waddr with rst_n high must not corrupt register 0. The other registers may go X; the bench must not drive X on these inputs.

Decomposition:
- Shared package constants:
  - REG_COUNT = 32
  - REG_ADDR_W = 5
  - REG_DATA_W = 32
  - ZERO_REG = 5'd0
- Sub-module decoder_5_32: inputs en and addr[4:0], output one-hot onehot[31:0]. It produces the per-register write enables.
- Storage: 31 flop-based registers built with generate, with async clear.
- Read selection reuses two mux_32_32 instances. Input 0 is tied to constant zero. When BYPASS=1, a compare-and-override stage follows each mux.

Test Plan:
- Reset: write 0xFFFFFFFF to all registers, assert rst_n low mid-cycle -> rdata1/rdata2 read 0 for addresses 0..31 immediately, before the next clk edge.
- Write then read: write reg[i]=i*0x01010101 for i=1..31 -> after each edge, rdata1(raddr1=i) = i*0x01010101 and rdata2(raddr2=31-i) matches its stored value.
- Zero register: we=1, waddr=0, wdata=0xDEADBEEF -> rdata1(raddr1=0)=0 and no other register changes.
- Enable gating: we=0, waddr=5, wdata=0x12345678, with reg5 holding 0x05050505 -> reg5 still reads 0x05050505 after the edge.
- Read-during-write: reg7=0xAAAA0000, we=1, waddr=7, wdata=0x0000BBBB, raddr1=raddr2=7:
  - BYPASS=0 -> 0xAAAA0000 before the edge, 0x0000BBBB after it.
  - BYPASS=1 -> 0x0000BBBB in the same cycle.
- Reset at edge: rst_n falls coincident with a write of 0x55555555 to reg3 -> reg3 reads 0. After deassertion, the first write of 0x3 to reg3 on the next edge reads back 0x3.
